// File: rtl/yacht_pkg.sv
// ---------------------------------------------------------------------------
// yacht_pkg : shared constants, category indices and sweep FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package yacht_pkg;

   localparam int NUM_CAT = 12;
   localparam int SCORE_W = 8;
   localparam int TOTAL_W = 9;
   localparam int CAT_W   = 4;
   localparam int UPPER_W = 7;

   localparam logic [CAT_W-1:0] CAT_ACES   = 4'd0;
   localparam logic [CAT_W-1:0] CAT_TWOS   = 4'd1;
   localparam logic [CAT_W-1:0] CAT_THREES = 4'd2;
   localparam logic [CAT_W-1:0] CAT_FOURS  = 4'd3;
   localparam logic [CAT_W-1:0] CAT_FIVES  = 4'd4;
   localparam logic [CAT_W-1:0] CAT_SIXES  = 4'd5;
   localparam logic [CAT_W-1:0] CAT_CHOICE = 4'd6;
   localparam logic [CAT_W-1:0] CAT_FOUR_K = 4'd7;
   localparam logic [CAT_W-1:0] CAT_FULL_H = 4'd8;
   localparam logic [CAT_W-1:0] CAT_S_STR  = 4'd9;
   localparam logic [CAT_W-1:0] CAT_L_STR  = 4'd10;
   localparam logic [CAT_W-1:0] CAT_YACHT  = 4'd11;

   localparam logic [CAT_W-1:0]   UPPER_LAST   = 4'd5;
   localparam logic [UPPER_W-1:0] BONUS_THRESH = 7'd63;
   localparam logic [TOTAL_W-1:0] BONUS_PTS    = 9'd35;
   localparam logic [CAT_W-1:0]   BEST_NONE    = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SWEEP  = 2'd1,
      ST_COMMIT = 2'd2
   } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/scorecard_bank.sv
// ---------------------------------------------------------------------------
// scorecard_bank : one player's used mask, upper-section sum and total
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scorecard_bank
   import yacht_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               commit,
   input  logic [CAT_W-1:0]   commit_idx,
   input  logic [SCORE_W-1:0] score,
   output logic [NUM_CAT-1:0] used,
   output logic [TOTAL_W-1:0] total
);

   logic [UPPER_W-1:0] upper;
   logic [UPPER_W:0]   upper_sum;
   logic               is_upper;
   logic               bonus_hit;
   logic [TOTAL_W-1:0] add;

   // Bonus fires only on the commit that crosses the threshold.
   always_comb begin
      is_upper  = (commit_idx <= UPPER_LAST);
      upper_sum = {1'b0, upper} + (is_upper ? score : '0);
      bonus_hit = is_upper && (upper < BONUS_THRESH) &&
                  (upper_sum >= {1'b0, BONUS_THRESH});
      add       = {1'b0, score} + (bonus_hit ? BONUS_PTS : '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         used  <= '0;
         upper <= '0;
         total <= '0;
      end else if (commit) begin
         used[commit_idx] <= 1'b1;
         if (is_upper)
            upper <= upper_sum[UPPER_W-1:0];
         total <= total + add;
      end
   end

endmodule

`default_nettype wire

// File: rtl/score_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// score_sweep_scheduler : sweeps the score calculator over all categories,
// tracks the best unused category and commits into per-player scorecards
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module score_sweep_scheduler
   import yacht_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start_sweep,
   input  logic               commit,
   input  logic [CAT_W-1:0]   commit_idx,
   input  logic               player,
   input  logic               new_game,
   input  logic [CAT_W-1:0]   ext_cat_idx,
   input  logic [SCORE_W-1:0] calc_score,
   output logic [CAT_W-1:0]   calc_sel,
   output logic               sweep_busy,
   output logic               sweep_done,
   output logic [CAT_W-1:0]   best_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic               commit_ack,
   output logic               commit_err,
   output logic [TOTAL_W-1:0] p1_total,
   output logic [TOTAL_W-1:0] p2_total,
   output logic [NUM_CAT-1:0] p1_used,
   output logic [NUM_CAT-1:0] p2_used,
   output logic               all_done
);

   sweep_state_t       state;
   sweep_state_t       next_state;
   logic [CAT_W-1:0]   cnt;
   logic [SCORE_W-1:0] cache [NUM_CAT];
   logic               sweep_valid;
   logic [CAT_W-1:0]   commit_idx_r;
   logic               commit_player_r;

   logic [NUM_CAT-1:0] used_sel;
   logic               commit_ok;
   logic               bank_commit;
   logic [SCORE_W-1:0] commit_score;

   assign used_sel     = player ? p2_used : p1_used;
   assign commit_ok    = sweep_valid && (commit_idx <= CAT_YACHT) && !used_sel[commit_idx];
   assign bank_commit  = (state == ST_COMMIT) && !new_game;
   assign commit_score = cache[commit_idx_r];
   assign calc_sel     = (state == ST_SWEEP) ? cnt : ext_cat_idx;
   assign sweep_busy   = (state == ST_SWEEP);
   assign all_done     = (&p1_used) && (&p2_used);

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (new_game) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (commit) begin
                  if (commit_ok)
                     next_state = ST_COMMIT;
               end else if (start_sweep) begin
                  next_state = ST_SWEEP;
               end
            end
            ST_SWEEP:  if (cnt == CAT_YACHT) next_state = ST_IDLE;
            ST_COMMIT: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || new_game) begin
         cnt             <= '0;
         sweep_valid     <= 1'b0;
         sweep_done      <= 1'b0;
         best_idx        <= BEST_NONE;
         best_score      <= '0;
         commit_ack      <= 1'b0;
         commit_err      <= 1'b0;
         commit_idx_r    <= '0;
         commit_player_r <= 1'b0;
         for (int i = 0; i < NUM_CAT; i++)
            cache[i] <= '0;
      end else begin
         sweep_done <= 1'b0;
         commit_ack <= 1'b0;
         commit_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (commit) begin
                  if (commit_ok) begin
                     commit_idx_r    <= commit_idx;
                     commit_player_r <= player;
                  end else begin
                     commit_err <= 1'b1;
                  end
               end else if (start_sweep) begin
                  cnt         <= '0;
                  sweep_valid <= 1'b0;
                  best_idx    <= BEST_NONE;
                  best_score  <= '0;
               end
            end
            ST_SWEEP: begin
               cache[cnt] <= calc_score;
               // Strict compare so a tie keeps the earlier (lower) index.
               if (!used_sel[cnt] && (calc_score > best_score)) begin
                  best_idx   <= cnt;
                  best_score <= calc_score;
               end
               cnt <= cnt + 1'b1;
               if (cnt == CAT_YACHT) begin
                  sweep_valid <= 1'b1;
                  sweep_done  <= 1'b1;
               end
               if (commit)
                  commit_err <= 1'b1;
            end
            ST_COMMIT: begin
               sweep_valid <= 1'b0;
               commit_ack  <= 1'b1;
               if (commit)
                  commit_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   scorecard_bank u_bank_p1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (new_game),
      .commit     (bank_commit && !commit_player_r),
      .commit_idx (commit_idx_r),
      .score      (commit_score),
      .used       (p1_used),
      .total      (p1_total)
   );

   scorecard_bank u_bank_p2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (new_game),
      .commit     (bank_commit && commit_player_r),
      .commit_idx (commit_idx_r),
      .score      (commit_score),
      .used       (p2_used),
      .total      (p2_total)
   );

endmodule

`default_nettype wire

// File: tb/tb_score_sweep_scheduler.sv
// ---------------------------------------------------------------------------
// tb_score_sweep_scheduler : directed table-driven bench for the sweep scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_score_sweep_scheduler;

   logic        clk = 1'b0;
   logic        reset_n, start_sweep, commit, player, new_game;
   logic [3:0]  commit_idx, ext_cat_idx;
   logic [7:0]  calc_score;
   logic [3:0]  calc_sel, best_idx;
   logic        sweep_busy, sweep_done, commit_ack, commit_err, all_done;
   logic [7:0]  best_score;
   logic [8:0]  p1_total, p2_total;
   logic [11:0] p1_used, p2_used;

   logic [11:0][7:0] tab;
   logic [11:0]      m1, m2;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Stand-in for the combinational score calculator.
   assign calc_score = (calc_sel < 4'd12) ? tab[calc_sel] : 8'd0;

   score_sweep_scheduler dut (
      .clk(clk), .reset_n(reset_n), .start_sweep(start_sweep), .commit(commit),
      .commit_idx(commit_idx), .player(player), .new_game(new_game),
      .ext_cat_idx(ext_cat_idx), .calc_score(calc_score), .calc_sel(calc_sel),
      .sweep_busy(sweep_busy), .sweep_done(sweep_done), .best_idx(best_idx),
      .best_score(best_score), .commit_ack(commit_ack), .commit_err(commit_err),
      .p1_total(p1_total), .p2_total(p2_total), .p1_used(p1_used),
      .p2_used(p2_used), .all_done(all_done)
   );

   typedef struct {
      bit               p;
      logic [11:0][7:0] s;
      logic [3:0]       idx;
      int               bi;
      int               bs;
      bit               ok;
      int               t1;
      int               t2;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [11:0][7:0] sc(input int a0, a1, a2, a3, a4, a5,
                                           a6, a7, a8, a9, a10, a11);
      logic [11:0][7:0] r;
      r[0] = 8'(a0);  r[1] = 8'(a1);   r[2]  = 8'(a2);  r[3]  = 8'(a3);
      r[4] = 8'(a4);  r[5] = 8'(a5);   r[6]  = 8'(a6);  r[7]  = 8'(a7);
      r[8] = 8'(a8);  r[9] = 8'(a9);   r[10] = 8'(a10); r[11] = 8'(a11);
      return r;
   endfunction

   task automatic do_sweep(input bit p, input logic [11:0][7:0] s);
      int n;
      player = p;
      tab = s;
      start_sweep = 1'b1;
      @(negedge clk);
      start_sweep = 1'b0;
      n = 0;
      while (!sweep_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("sweep_done_seen", int'(sweep_done), 1);
   endtask

   task automatic do_commit(input logic [3:0] idx, input bit ok,
                            input int t1, input int t2, input bit exp_all);
      commit = 1'b1;
      commit_idx = idx;
      @(negedge clk);
      commit = 1'b0;
      chk("commit_err_k1", int'(commit_err), int'(!ok));
      chk("commit_ack_k1", int'(commit_ack), 0);
      @(negedge clk);
      if (ok) begin
         if (player) m2[idx] = 1'b1;
         else        m1[idx] = 1'b1;
      end
      chk("commit_ack_k2", int'(commit_ack), int'(ok));
      chk("commit_err_k2", int'(commit_err), 0);
      chk("p1_total", int'(p1_total), t1);
      chk("p2_total", int'(p2_total), t2);
      chk("p1_used", int'(p1_used), int'(m1));
      chk("p2_used", int'(p2_used), int'(m2));
      chk("all_done", int'(all_done), int'(exp_all));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_calc_sel"}, int'(calc_sel), int'(ext_cat_idx));
      chk({tag, "_busy"}, int'(sweep_busy), 0);
      chk({tag, "_done"}, int'(sweep_done), 0);
      chk({tag, "_best_idx"}, int'(best_idx), 15);
      chk({tag, "_best_score"}, int'(best_score), 0);
      chk({tag, "_ack"}, int'(commit_ack), 0);
      chk({tag, "_err"}, int'(commit_err), 0);
      chk({tag, "_p1_total"}, int'(p1_total), 0);
      chk({tag, "_p2_total"}, int'(p2_total), 0);
      chk({tag, "_p1_used"}, int'(p1_used), 0);
      chk({tag, "_p2_used"}, int'(p2_used), 0);
      chk({tag, "_all_done"}, int'(all_done), 0);
   endtask

   initial begin
      logic [11:0][7:0] t6, t5, t4, t1, s2, s3, ones;
      int e1, e2;
      bit seen;

      t6   = sc(0, 0, 0, 0, 0, 30, 30, 30, 30, 0, 0, 50);
      t5   = sc(0, 0, 0, 0, 25, 0, 25, 25, 25, 0, 0, 50);
      t4   = sc(0, 0, 0, 12, 0, 0, 12, 0, 0, 15, 0, 0);
      t1   = sc(3, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
      s2   = sc(1, 2, 3, 4, 5, 0, 15, 0, 0, 15, 30, 0);
      s3   = sc(0, 0, 0, 0, 0, 0, 30, 0, 0, 0, 30, 0);
      ones = sc(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);

      //          p    scores idx    best  score ok  p1   p2
      vecs[0]  = '{1'b0, t6, 4'd5,  11, 50, 1'b1, 30,  0};
      vecs[1]  = '{1'b0, t5, 4'd4,  11, 50, 1'b1, 55,  0};
      vecs[2]  = '{1'b0, t4, 4'd3,   9, 15, 1'b1, 102, 0};
      vecs[3]  = '{1'b0, t1, 4'd0,   0,  3, 1'b1, 105, 0};
      vecs[4]  = '{1'b0, t6, 4'd5,  11, 50, 1'b0, 105, 0};
      vecs[5]  = '{1'b0, t6, 4'd12, 11, 50, 1'b0, 105, 0};
      vecs[6]  = '{1'b0, s2, 4'd6,  10, 30, 1'b1, 120, 0};
      vecs[7]  = '{1'b0, s2, 4'd10, 10, 30, 1'b1, 150, 0};
      vecs[8]  = '{1'b0, s2, 4'd9,   9, 15, 1'b1, 165, 0};
      vecs[9]  = '{1'b1, s3, 4'd6,   6, 30, 1'b1, 165, 30};
      vecs[10] = '{1'b1, t6, 4'd11, 11, 50, 1'b1, 165, 80};

      reset_n = 1'b0; start_sweep = 1'b0; commit = 1'b0; player = 1'b0;
      new_game = 1'b0; commit_idx = 4'd0; ext_cat_idx = 4'd7; tab = t6;
      m1 = '0; m2 = '0;
      repeat (2) @(negedge clk);
      chk_reset_state("rst0");
      reset_n = 1'b1;
      @(negedge clk);

      // Commit before any sweep has completed.
      do_commit(4'd0, 1'b0, 0, 0, 1'b0);

      // Cycle-exact sweep with a stray commit and start_sweep mid-sweep.
      player = 1'b0;
      tab = t6;
      start_sweep = 1'b1;
      @(negedge clk);
      start_sweep = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("sweep_calc_sel", int'(calc_sel), i);
         chk("sweep_busy", int'(sweep_busy), 1);
         chk("sweep_done_early", int'(sweep_done), 0);
         if (i == 4) chk("commit_err_in_sweep", int'(commit_err), 1);
         commit = (i == 3);
         commit_idx = 4'd5;
         start_sweep = (i == 6);
         @(negedge clk);
      end
      commit = 1'b0;
      start_sweep = 1'b0;
      chk("sweep_done_k13", int'(sweep_done), 1);
      chk("sweep_busy_k13", int'(sweep_busy), 0);
      chk("sweep_best_idx", int'(best_idx), 11);
      chk("sweep_best_score", int'(best_score), 50);
      chk("idle_calc_sel", int'(calc_sel), 7);
      @(negedge clk);
      chk("done_pulse_once", int'(sweep_done), 0);
      chk("no_restart", int'(sweep_busy), 0);

      for (int r = 0; r < 11; r++) begin
         do_sweep(vecs[r].p, vecs[r].s);
         chk($sformatf("row%0d_best_idx", r), int'(best_idx), vecs[r].bi);
         chk($sformatf("row%0d_best_score", r), int'(best_score), vecs[r].bs);
         do_commit(vecs[r].idx, vecs[r].ok, vecs[r].t1, vecs[r].t2, 1'b0);
      end

      // sweep_valid was consumed by the last commit.
      do_commit(4'd0, 1'b0, 165, 80, 1'b0);

      // new_game during sweep cycle 5 together with start_sweep.
      player = 1'b0;
      tab = t6;
      start_sweep = 1'b1;
      @(negedge clk);
      start_sweep = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_calc_sel", int'(calc_sel), 5);
      new_game = 1'b1;
      start_sweep = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      start_sweep = 1'b0;
      m1 = '0;
      m2 = '0;
      chk_reset_state("newgame");
      seen = 1'b0;
      repeat (16) begin
         if (sweep_done || sweep_busy) seen = 1'b1;
         @(negedge clk);
      end
      chk("no_done_after_abort", int'(seen), 0);

      // Fill every category, alternating players.
      e1 = 0;
      e2 = 0;
      for (int i = 0; i < 12; i++) begin
         for (int p = 0; p < 2; p++) begin
            do_sweep(p[0], ones);
            chk("fill_best_idx", int'(best_idx), i);
            chk("fill_best_score", int'(best_score), 1);
            if (p == 0) e1++;
            else        e2++;
            do_commit(4'(i), 1'b1, e1, e2, (i == 11) && (p == 1));
         end
      end

      reset_n = 1'b0;
      ext_cat_idx = 4'd3;
      @(negedge clk);
      chk_reset_state("rst1");
      reset_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
